// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display-port UART transmitter:
//   - state_e    : transmitter FSM states
//   - ASCII_*    : character constants used by the hex-dump mode
//   - hex_ascii  : maps a 4-bit nibble to its uppercase hex ASCII character
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/display_fifo.sv
// -----------------------------------------------------------------------------
// display_fifo
// Synchronous byte FIFO buffering captured display values for the UART.
// The head entry is presented combinationally on dout_o.
//
// Parameters:
//   FIFO_DEPTH : number of entries (power of two, >= 2)
//   FIFO_AW    : log2(FIFO_DEPTH)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (clears pointers and count)
//   push_i   in   write din_i at the tail this edge (caller guarantees room)
//   pop_i    in   drop the head entry this edge (caller guarantees non-empty)
//   din_i    in   [7:0] write data
//   dout_o   out  [7:0] head entry
//   count_o  out  [FIFO_AW:0] registered occupancy
//   full_o   out  occupancy == FIFO_DEPTH
//   empty_o  out  occupancy == 0
// -----------------------------------------------------------------------------
module display_fifo
    import display_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [7:0]         din_i,
    output logic [7:0]         dout_o,
    output logic [FIFO_AW:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam logic [FIFO_AW:0] FULL_COUNT = FIFO_DEPTH[FIFO_AW:0];

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    // NOTE: the storage array is deliberately not reset; validity is defined
    // by the pointers and count alone, so the array stays plain storage.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/display_uart_tx.sv
// -----------------------------------------------------------------------------
// display_uart_tx
// Captures each value strobed on the processor's display port, buffers it in
// a small FIFO and serializes it as UART 8N1 (LSB first, idle high).
//
// Build option:
//   DISPLAY_ASCII_HEX_EN  when defined, every value is sent as three frames:
//                         upper-nibble hex ASCII, lower-nibble hex ASCII, LF.
//                         When undefined, the raw byte is sent as one frame.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit period (>= 2)
//   FIFO_DEPTH   : buffer entries (power of two, >= 2)
//   FIFO_AW      : log2(FIFO_DEPTH)
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset; aborts any frame
//   disp_data   in   [7:0] display value
//   disp_valid  in   capture disp_data at this edge
//   tx          out  UART serial line (registered, idle high)
//   tx_busy     out  transmitter active (registered)
//   fifo_empty  out  FIFO holds no entries
//   fifo_full   out  FIFO holds FIFO_DEPTH entries
//   fifo_count  out  [FIFO_AW:0] FIFO occupancy
//   overflow    out  sticky: a capture was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module display_uart_tx
    import display_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         disp_data,
    input  logic               disp_valid,
    output logic               tx,
    output logic               tx_busy,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
`ifdef DISPLAY_ASCII_HEX_EN
    logic [1:0]        char_idx_q, char_idx_d;  // next character of the current value
    logic [7:0]        hold_q, hold_d;          // popped value while its chars are sent
`endif

    logic       push;
    logic       pop;
    logic       launch;
    logic       baud_last;
    logic [7:0] fifo_dout;
    logic       fifo_empty_w;
    logic       fifo_full_w;

    // A push into a full FIFO is still legal when the head leaves on the
    // same edge.
    assign push       = disp_valid && (!fifo_full_w || pop);
    assign overflow_d = overflow_q || (disp_valid && !push);

    display_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (disp_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        launch    = 1'b0;
`ifdef DISPLAY_ASCII_HEX_EN
        char_idx_d = char_idx_q;
        hold_d     = hold_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
`ifdef DISPLAY_ASCII_HEX_EN
                // Only the first character of a value consumes a FIFO entry;
                // the other two are built from the held value.
                if (char_idx_q == 2'd0) begin
                    if (!fifo_empty_w) begin
                        pop        = 1'b1;
                        hold_d     = fifo_dout;
                        shift_d    = hex_ascii(fifo_dout[7:4]);
                        char_idx_d = 2'd1;
                        launch     = 1'b1;
                    end
                end else if (char_idx_q == 2'd1) begin
                    shift_d    = hex_ascii(hold_q[3:0]);
                    char_idx_d = 2'd2;
                    launch     = 1'b1;
                end else begin
                    shift_d    = ASCII_LF;
                    char_idx_d = 2'd0;
                    launch     = 1'b1;
                end
`else
                if (!fifo_empty_w) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    launch  = 1'b1;
                end
`endif
                if (launch) begin
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d    = '0;
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end

            DATA: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        // Next bit is driven now so tx stays registered.
                        tx_d      = shift_q[1];
                    end
                end
            end

            STOP: begin
                baud_d = baud_q + 1'b1;
                tx_d   = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

`ifdef DISPLAY_ASCII_HEX_EN
        // Busy stays high across the one-cycle gaps between chars of a value.
        busy_d = (state_d != IDLE) || (char_idx_d != 2'd0);
`else
        busy_d = (state_d != IDLE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef DISPLAY_ASCII_HEX_EN
            char_idx_q <= '0;
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef DISPLAY_ASCII_HEX_EN
            char_idx_q <= char_idx_d;
            hold_q     <= hold_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign overflow   = overflow_q;
    assign fifo_empty = fifo_empty_w;
    assign fifo_full  = fifo_full_w;

endmodule

// File: tb/tb_display_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_display_uart_tx
// Directed stimulus for display_uart_tx with CLKS_PER_BIT=4. Expected frames
// are queued when values are pushed; a UART receiver process decodes tx and
// compares each received frame against the head of the queue. FIFO status,
// overflow and reset behaviour are checked directly by the stimulus process.
// Honours DISPLAY_ASCII_HEX_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_display_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [7:0]    disp_data  = 8'h00;
    logic          disp_valid = 1'b0;
    logic          tx;
    logic          tx_busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    exp_q[$];

    always #5 clk = ~clk;

    display_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Queue the frames a pushed value should produce.
    task automatic expect_value(input logic [7:0] v);
`ifdef DISPLAY_ASCII_HEX_EN
        exp_q.push_back(hex_char(v[7:4]));
        exp_q.push_back(hex_char(v[3:0]));
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(v);
`endif
    endtask

    // Wait (bounded) until every expected frame arrived and the DUT is idle.
    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !tx_busy && fifo_empty) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, (exp_q.size() == 0 && !tx_busy && fifo_empty), 1);
    endtask

    // UART receiver / scoreboard monitor
    initial begin : monitor
        logic       prev;
        logic [7:0] rx;
        logic       start_b;
        logic       stop_b;
        logic       aborted;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !tx) begin
                aborted = 1'b0;
                rx      = 8'h00;
                start_b = 1'b1;
                stop_b  = 1'b0;
                for (int c = 1; c <= 37; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 2) start_b = tx;
                    if (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) rx = {tx, rx[7:1]};
                    if (c == 37) stop_b = tx;
                end
                if (!aborted) begin
                    check("rx_start_bit", start_b, 0);
                    check("rx_stop_bit", stop_b, 1);
                    check("rx_frame_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("rx_frame_data", rx, exp_b);
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, summary not printed normally");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [9:0] exp_55;
        logic       exp_busy_after;
        int         mism;
        logic       busy39;
        int         n;

        // Level of tx in each of the 10 bit periods of the first frame.
`ifdef DISPLAY_ASCII_HEX_EN
        exp_55         = 10'b1001101010;  // '5' = 0x35
        exp_busy_after = 1'b1;
`else
        exp_55         = 10'b1010101010;  // 0x55
        exp_busy_after = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single value 0x55: bit-exact waveform and busy window
        disp_data  = 8'h55;
        disp_valid = 1'b1;
        expect_value(8'h55);
        @(negedge clk);
        disp_valid = 1'b0;
        mism   = 0;
        busy39 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== exp_55[i / 4]) mism++;
            if (i == 39) busy39 = tx_busy;
        end
        check("tx_55_waveform_mismatches", mism, 0);
        check("tx_busy_last_frame_cycle", busy39, 1);
        @(negedge clk);
        check("tx_busy_after_frame", tx_busy, exp_busy_after);
        wait_drain(2000, "drain_55");

        // Nine consecutive pushes: first is popped at once, eight remain
        for (int k = 0; k < 9; k++) begin
            disp_data  = 8'(k);
            disp_valid = 1'b1;
            expect_value(8'(k));
            @(negedge clk);
        end
        disp_valid = 1'b0;
        check("fill_count", fifo_count, 8);
        check("fill_full", fifo_full, 1);
        check("fill_empty", fifo_empty, 0);
        check("fill_overflow", overflow, 0);

        // Push while full, coinciding with the next IDLE pop: accepted
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy_drop", tx_busy, 0);
        disp_data  = 8'h09;
        disp_valid = 1'b1;
        expect_value(8'h09);
        @(negedge clk);
        check("coincide_count", fifo_count, 8);
        check("coincide_overflow", overflow, 0);

        // Push while full with no pop: dropped, overflow sticks
        disp_data = 8'hFF;
        @(negedge clk);
        disp_valid = 1'b0;
        check("reject_overflow", overflow, 1);
        check("reject_count", fifo_count, 8);
        wait_drain(8000, "drain_fill");
        check("overflow_sticky", overflow, 1);

        // Reset in the middle of a frame (DATA bit 3 in raw mode)
        disp_data  = 8'hA5;
        disp_valid = 1'b1;
        @(negedge clk);
        disp_data  = 8'h3C;
        @(negedge clk);
        disp_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_frame_busy", tx_busy, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_tx_busy", tx_busy, 0);
        check("abort_fifo_count", fifo_count, 0);
        check("abort_fifo_empty", fifo_empty, 1);
        check("abort_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean frame after reset
        disp_data  = 8'h01;
        disp_valid = 1'b1;
        expect_value(8'h01);
        @(negedge clk);
        disp_valid = 1'b0;
        wait_drain(2000, "drain_after_reset");

        // 0x2A: hex-dump characters or raw byte depending on the build
        disp_data  = 8'h2A;
        disp_valid = 1'b1;
`ifdef DISPLAY_ASCII_HEX_EN
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h2A);
`endif
        @(negedge clk);
        disp_valid = 1'b0;
        wait_drain(2000, "drain_2a");
        check("final_overflow", overflow, 0);

        // Quiet period: any stray frame is flagged by the monitor
        repeat (60) @(negedge clk);
        check("final_tx_idle", tx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
- Downstream consumer of the processor's 8-bit display port.
- Captures each displayed value, buffers it in a small FIFO, and serializes it on a UART 8N1 line.
- The program output (e.g. the Fibonacci sequence) can then be read off a serial pin or a bench UART monitor instead of only a waveform.
- Sits between the processor core's display output and the board's TX pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit period (≥2)
- FIFO_DEPTH, 8, buffer entries (power of two, ≥2)
- FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
- clk  in  1  processor clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- disp_data  in  8  value presented by the processor display port
- disp_valid  in  1  one-cycle strobe: capture disp_data this edge
- tx  out  1  UART serial output, idle high
- tx_busy  out  1  FSM not in IDLE
- fifo_empty  out  1  FIFO holds 0 entries
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_count  out  FIFO_AW+1  current occupancy
- overflow  out  1  sticky: a capture was dropped

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high. While rst=1: tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers=0.
- All outputs are registered. fifo_empty, fifo_full and fifo_count are derived from the registered count.
- Push: accepted at an edge with disp_valid=1 if !fifo_full, or if a pop happens at the same edge.
- Rejected push: data discarded; overflow set to 1 and held until reset.
- Simultaneous push+pop: count unchanged; both pointers advance. With count=0, a push and a pop cannot coincide, because a pop requires non-empty.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
- IDLE: if !fifo_empty, pop the head into the shift register, clear the baud counter, go to START, drive tx=0.
- START: after CLKS_PER_BIT cycles go to DATA with bit index 0.
- DATA: drive tx=shift[0]. Each bit lasts CLKS_PER_BIT cycles, LSB first. After bit 7 go to STOP.
- STOP: drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: disp_valid sampled at edge E0 → pop at E1 → tx low from E1.
- Frame length: 10×CLKS_PER_BIT cycles. A back-to-back frame's start bit begins exactly one cycle after the previous stop period ends, so the gap is 1 cycle.
- A reset mid-frame aborts the frame immediately (tx=1) and discards FIFO contents.
- disp_data is sampled only on disp_valid. Holding disp_valid high pushes every cycle.

Optional Feature:
- Macro: DISPLAY_ASCII_HEX_EN.
- Defined: each popped byte is sent as three frames: upper-nibble hex ASCII, lower-nibble hex ASCII, then 0x0A.
  - Digits 0-9 map to 0x30-0x39; A-F map to uppercase 0x41-0x46.
  - A 2-bit char index is added. A pop occurs only when the index is 0 and the FSM is in IDLE.
  - Chars 1 and 2 start from IDLE without a pop. Each still has the 1-cycle inter-frame gap.
  - tx_busy stays 1 between the three chars of one value.
- Undefined: raw byte, one frame per value.

Decomposition:
- Package display_pkg holds:
  - state enum {IDLE, START, DATA, STOP}
  - ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41
  - a function mapping a nibble to its hex ASCII character
- One sub-module, display_fifo: synchronous FIFO, parameters FIFO_DEPTH/FIFO_AW, ports push/pop/din/dout/count/full/empty.
  - dout is valid combinationally from the head entry.
  - Overflow tracking stays in the top level.

Test Plan:
- CLKS_PER_BIT=4, push 0x55 → tx from the edge after the push: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1. tx_busy high for 40 cycles.
- Push 0x00..0x08 on 9 consecutive edges → after the 9th push, fifo_count=8 and fifo_full=1, overflow=0. All 9 bytes are received in order.
- Continuing from that state, push 0xFF while full with no pop → 0xFF is never transmitted and overflow=1 until rst.
- FIFO full, and the push coincides with the IDLE pop (end of a frame) → push accepted, count stays 8, overflow stays 0.
- Assert rst during DATA bit 3 of 0xA5 → tx=1 immediately, fifo_count=0. After release, a new push of 0x01 transmits cleanly.
- With DISPLAY_ASCII_HEX_EN defined, push 0x2A → frames 0x32, 0x41, 0x0A. With it undefined → a single frame 0x2A.
